// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Program loader for the instruction memory of the single-cycle MIPS core.
// It receives a framed byte stream over a valid/ready handshake:
//
//   MAGIC, CNT_HI, CNT_LO, N x {B3, B2, B1, B0}, CSUM
//
// N = {CNT_HI, CNT_LO}. Each group of four bytes is assembled MSB-first into
// a 32-bit word and written to consecutive word addresses starting at 0.
// CSUM is the 8-bit modular sum of CNT_HI, CNT_LO and every data byte.
// The core stays in reset (cpu_rstn low) until a frame finishes with a
// matching checksum.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   in_data   stream byte
//   in_valid  in_data valid this cycle
//   in_ready  loader accepts a byte (transfer when in_valid && in_ready)
//   start     one-cycle pulse, re-arms the loader from DONE or ERR
//   im_we     instruction-memory write strobe, one cycle per word
//   im_addr   word address of the write
//   im_wdata  word being written
//   cpu_rstn  active-low reset to the core, high only in DONE
//   done      frame loaded and checksum good (level)
//   err       frame rejected (level)
//   err_code  0 none, 1 count too large, 2 checksum mismatch
//
// Every output is a flop; in_data only reaches the outputs through
// registered state, so there is no combinational path from the stream.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] MAGIC  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rstn,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // Memory capacity in words; 17 bits so that a full 16-bit count can be
    // compared against it without overflow.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_COUNT = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;

    // ---------------------------------------------------------------- state
    state_t      state, state_n;
    logic [15:0] count, count_n;         // N from the frame header
    logic [16:0] word_idx, word_idx_n;   // index of the word being assembled
    logic [1:0]  byte_idx, byte_idx_n;   // position inside the current word
    logic [23:0] asm_q, asm_n;           // first three bytes of current word
    logic [7:0]  sum, sum_n;             // running checksum

    // registered outputs, next values
    logic              in_ready_n;
    logic              im_we_n;
    logic [ADDR_W-1:0] im_addr_n;
    logic [31:0]       im_wdata_n;
    logic              cpu_rstn_n;
    logic              done_n;
    logic              err_n;
    logic [1:0]        err_code_n;

    logic        accept;
    logic [15:0] new_count;

    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            asm_q    <= '0;
            sum      <= '0;
            in_ready <= 1'b1;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            cpu_rstn <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_n;
            count    <= count_n;
            word_idx <= word_idx_n;
            byte_idx <= byte_idx_n;
            asm_q    <= asm_n;
            sum      <= sum_n;
            in_ready <= in_ready_n;
            im_we    <= im_we_n;
            im_addr  <= im_addr_n;
            im_wdata <= im_wdata_n;
            cpu_rstn <= cpu_rstn_n;
            done     <= done_n;
            err      <= err_n;
            err_code <= err_code_n;
        end
    end

    // -------------------------------------------------- next state / outputs
    always_comb begin
        state_n    = state;
        count_n    = count;
        word_idx_n = word_idx;
        byte_idx_n = byte_idx;
        asm_n      = asm_q;
        sum_n      = sum;
        im_we_n    = 1'b0;
        im_addr_n  = im_addr;     // address/data hold between writes
        im_wdata_n = im_wdata;
        err_code_n = err_code;
        new_count  = {count[15:8], in_data};

        unique case (state)
            S_IDLE: begin
                // Anything but the start byte is consumed and dropped.
                if (accept && in_data == MAGIC) begin
                    state_n    = S_CNT_HI;
                    sum_n      = '0;
                    byte_idx_n = '0;
                end
            end

            S_CNT_HI: begin
                if (accept) begin
                    count_n[15:8] = in_data;
                    sum_n         = in_data;
                    state_n       = S_CNT_LO;
                end
            end

            S_CNT_LO: begin
                if (accept) begin
                    count_n    = new_count;
                    sum_n      = sum + in_data;
                    word_idx_n = '0;
                    byte_idx_n = '0;
                    if ({1'b0, new_count} > CAPACITY) begin
                        state_n    = S_ERR;
                        err_code_n = ERR_COUNT;
                    end else if (new_count == 16'd0) begin
                        state_n = S_CSUM;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    sum_n      = sum + in_data;
                    asm_n      = {asm_q[15:0], in_data};
                    byte_idx_n = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        // Word complete: the write strobe is registered here,
                        // so it shows up in the cycle after this accept and
                        // overlaps byte 0 of the next word.
                        im_we_n    = 1'b1;
                        im_addr_n  = word_idx[ADDR_W-1:0];
                        im_wdata_n = {asm_q, in_data};
                        word_idx_n = word_idx + 17'd1;
                        if (word_idx + 17'd1 == {1'b0, count})
                            state_n = S_CSUM;
                    end
                end
            end

            S_CSUM: begin
                if (accept) begin
                    if (in_data == sum) begin
                        state_n = S_DONE;
                    end else begin
                        state_n    = S_ERR;
                        err_code_n = ERR_CSUM;
                    end
                end
            end

            S_DONE: begin
                if (start)
                    state_n = S_IDLE;
            end

            S_ERR: begin
                if (start) begin
                    state_n    = S_IDLE;
                    err_code_n = ERR_NONE;
                end
            end

            default: state_n = S_IDLE;
        endcase

        // Status flags are decoded from the next state so they change on the
        // same edge as the state itself (e.g. cpu_rstn drops with start).
        in_ready_n = (state_n != S_DONE) && (state_n != S_ERR);
        done_n     = (state_n == S_DONE);
        cpu_rstn_n = (state_n == S_DONE);
        err_n      = (state_n == S_ERR);
    end

endmodule
